// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the control FSM's MemRead/MemWrite
// strobes. It latches one request and inserts WAIT_CYCLES wait states. It then
// accesses an internal synchronous RAM and pulses Ready. Busy stays high for
// the whole transaction.
// Optional feature: define MEM_MMIO_EN to map the all-ones address onto the
// IOOut register instead of RAM.
module mem_responder #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Ready,
    output logic              Busy,
    output logic              Err,
    output logic [DATA_W-1:0] IOOut
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic                r_isWrite;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [3:0]          r_waitCnt;
    logic [DATA_W-1:0]   r_readData;
    logic [DATA_W-1:0]   r_ram [DEPTH];
    logic                w_accept;
    logic                w_illegal;
    logic                w_ramWe;

    // Requests are only looked at while idle; exactly one strobe is a legal request
    assign w_accept  = (r_state == ST_IDLE) && (MemRead ^ MemWrite);
    assign w_illegal = (r_state == ST_IDLE) && MemRead && MemWrite;

`ifdef MEM_MMIO_EN
    logic                w_isIo;
    logic [DATA_W-1:0]   r_ioOut;

    assign w_isIo  = (r_addr == {ADDR_W{1'b1}});
    assign w_ramWe = (r_state == ST_ACCESS) && r_isWrite && !w_isIo;
    assign IOOut   = r_ioOut;

    // The MMIO output register is updated at the closing edge of a write's ACCESS cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ioOut <= '0;
        end else if ((r_state == ST_ACCESS) && r_isWrite && w_isIo) begin
            r_ioOut <= r_wdata;
        end
    end
`else
    assign w_ramWe = (r_state == ST_ACCESS) && r_isWrite;
    assign IOOut   = '0;
`endif

    // State register; reset always wins over any strobe in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; the counter holds the remaining wait cycles, including the current one
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_illegal) begin
                    w_nextState = ST_ERROR;
                end else if (w_accept) begin
                    w_nextState = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_waitCnt <= 4'd1) begin
                    w_nextState = ST_ACCESS;
                end
            end
            ST_ACCESS: w_nextState = ST_DONE;
            ST_DONE:   w_nextState = ST_IDLE;
            ST_ERROR:  w_nextState = ST_IDLE;
            default:   w_nextState = ST_IDLE;
        endcase
    end

    // Request capture and wait countdown; an illegal request captures nothing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_isWrite <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_waitCnt <= 4'd0;
        end else if (w_accept) begin
            r_isWrite <= MemWrite;
            r_addr    <= Addr;
            r_wdata   <= WriteData;
            r_waitCnt <= WAIT_INIT;
        end else if ((r_state == ST_WAIT) && (r_waitCnt != 4'd0)) begin
            r_waitCnt <= r_waitCnt - 4'd1;
        end
    end

    // RAM write port; contents survive reset, but a write whose ACCESS edge coincides with reset is dropped
    always_ff @(posedge clk) begin
        if (!rst && w_ramWe) begin
            r_ram[r_addr] <= r_wdata;
        end
    end

    // Read result register; only a read's ACCESS edge changes it, so it holds across writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_readData <= '0;
        end else if ((r_state == ST_ACCESS) && !r_isWrite) begin
`ifdef MEM_MMIO_EN
            if (w_isIo) begin
                r_readData <= r_ioOut;
            end else begin
                r_readData <= r_ram[r_addr];
            end
`else
            r_readData <= r_ram[r_addr];
`endif
        end
    end

    assign ReadData = r_readData;
    assign Ready    = (r_state == ST_DONE);
    assign Err      = (r_state == ST_ERROR);
    assign Busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder. Two instances share the same stimulus:
// dut1 with one wait state and dut0 with none. Expected results are queued
// when a request is driven and compared when each instance pulses Ready.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] Addr;
    logic [7:0] WriteData;

    logic [7:0] rd1, io1, rd0, io0;
    logic       ready1, busy1, err1;
    logic       ready0, busy0, err0;

    typedef struct {
        logic       isRead;
        logic [7:0] data;
        logic [7:0] io;
        int         issue;
    } exp_t;

    exp_t       q1[$];
    exp_t       q0[$];
    exp_t       e1;
    exp_t       e0;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         readyCount1 = 0;
    int         readyCount0 = 0;
    logic [7:0] model [256];
    logic [7:0] lastRead = 8'h00;
    logic [7:0] modelIo = 8'h00;

    always #5 clk = ~clk;

    // Cycle counter used to measure request-to-Ready latency
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .Addr(Addr), .WriteData(WriteData), .ReadData(rd1), .Ready(ready1),
        .Busy(busy1), .Err(err1), .IOOut(io1)
    );

    mem_responder #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .Addr(Addr), .WriteData(WriteData), .ReadData(rd0), .Ready(ready0),
        .Busy(busy0), .Err(err0), .IOOut(io0)
    );

    // Scoreboard for the one-wait-state instance
    always @(negedge clk) begin
        if (ready1 === 1'b1) begin
            readyCount1++;
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("[TB] FAIL dut1_unexpected_ready: got Ready=1, expected no pending request");
            end else begin
                e1 = q1.pop_front();
                checks++;
                if (rd1 !== e1.data) begin
                    errors++;
                    $display("[TB] FAIL dut1_readdata: got %h, expected %h", rd1, e1.data);
                end
                checks++;
                if ((cyc - e1.issue + 1) !== 3) begin
                    errors++;
                    $display("[TB] FAIL dut1_latency: got %0d, expected 3", cyc - e1.issue + 1);
                end
                checks++;
                if (io1 !== e1.io) begin
                    errors++;
                    $display("[TB] FAIL dut1_ioout: got %h, expected %h", io1, e1.io);
                end
            end
        end
    end

    // Scoreboard for the zero-wait-state instance
    always @(negedge clk) begin
        if (ready0 === 1'b1) begin
            readyCount0++;
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("[TB] FAIL dut0_unexpected_ready: got Ready=1, expected no pending request");
            end else begin
                e0 = q0.pop_front();
                checks++;
                if (rd0 !== e0.data) begin
                    errors++;
                    $display("[TB] FAIL dut0_readdata: got %h, expected %h", rd0, e0.data);
                end
                checks++;
                if ((cyc - e0.issue + 1) !== 2) begin
                    errors++;
                    $display("[TB] FAIL dut0_latency: got %0d, expected 2", cyc - e0.issue + 1);
                end
                checks++;
                if (io0 !== e0.io) begin
                    errors++;
                    $display("[TB] FAIL dut0_ioout: got %h, expected %h", io0, e0.io);
                end
            end
        end
    end

    // Drive one request for 'hold' cycles and queue its expected outcome
    task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] a,
                                 input logic [7:0] d, input int hold);
        exp_t e;
        @(negedge clk);
        MemRead   = rd;
        MemWrite  = wr;
        Addr      = a;
        WriteData = d;
        if (rd ^ wr) begin
            if (wr) begin
`ifdef MEM_MMIO_EN
                if (a == 8'hFF) modelIo = d;
                else model[a] = d;
`else
                model[a] = d;
`endif
            end else begin
`ifdef MEM_MMIO_EN
                if (a == 8'hFF) lastRead = modelIo;
                else lastRead = model[a];
`else
                lastRead = model[a];
`endif
            end
            e.isRead = rd;
            e.data   = lastRead;
            e.io     = modelIo;
            e.issue  = cyc + 1;
            q1.push_back(e);
            q0.push_back(e);
        end
        repeat (hold) @(negedge clk);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy0 !== 1'b0 || busy1 !== 1'b0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wait_idle_timeout: got Busy0=%b Busy1=%b, expected 0", busy0, busy1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        Addr = 8'h00;
        WriteData = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({rd1, ready1, busy1, err1, io1} !== 19'h0) begin
            errors++;
            $display("[TB] FAIL reset_dut1: got rd=%h rdy=%b busy=%b err=%b io=%h, expected all 0",
                     rd1, ready1, busy1, err1, io1);
        end
        checks++;
        if ({rd0, ready0, busy0, err0, io0} !== 19'h0) begin
            errors++;
            $display("[TB] FAIL reset_dut0: got rd=%h rdy=%b busy=%b err=%b io=%h, expected all 0",
                     rd0, ready0, busy0, err0, io0);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        applyStimulus(1'b0, 1'b1, 8'h10, 8'hA5, 1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy1 !== (i < 3)) begin
                errors++;
                $display("[TB] FAIL busy_profile_cycle%0d: got %b, expected %b", i + 1, busy1, (i < 3));
            end
            @(negedge clk);
        end
        waitIdle();
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 1);
        waitIdle();
        checks++;
        if (rd1 !== 8'hA5 || rd0 !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL read_back_10: got %h/%h, expected a5", rd1, rd0);
        end
    endtask

    task automatic test_zero_wait();
        int rc0;
        int rc1;
        applyStimulus(1'b0, 1'b1, 8'h20, 8'h3C, 1);
        waitIdle();
        rc0 = readyCount0;
        rc1 = readyCount1;
        applyStimulus(1'b1, 1'b0, 8'h20, 8'h00, 2);
        checks++;
        if (busy0 !== 1'b1 || ready0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dut0_done_cycle: got busy=%b ready=%b, expected 1/1", busy0, ready0);
        end
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dut0_strobe_in_done_dropped: got busy=%b, expected 0", busy0);
        end
        waitIdle();
        repeat (3) @(negedge clk);
        checks++;
        if ((readyCount0 - rc0) !== 1 || (readyCount1 - rc1) !== 1) begin
            errors++;
            $display("[TB] FAIL dropped_strobe_ready_count: got %0d/%0d, expected 1/1",
                     readyCount0 - rc0, readyCount1 - rc1);
        end
        checks++;
        if (rd0 !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL dut0_read_20: got %h, expected 3c", rd0);
        end
    endtask

    task automatic test_illegal();
        int rc1;
        rc1 = readyCount1;
        applyStimulus(1'b1, 1'b1, 8'h10, 8'hEE, 1);
        checks++;
        if (err1 !== 1'b1 || err0 !== 1'b1 || busy1 !== 1'b1 || busy0 !== 1'b1 || ready1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal_err_pulse: got err=%b/%b busy=%b/%b ready=%b, expected 1/1 1/1 0",
                     err1, err0, busy1, busy0, ready1);
        end
        @(negedge clk);
        checks++;
        if (err1 !== 1'b0 || busy1 !== 1'b0 || err0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal_err_end: got err=%b/%b busy=%b, expected 0/0 0", err1, err0, busy1);
        end
        waitIdle();
        checks++;
        if (readyCount1 !== rc1) begin
            errors++;
            $display("[TB] FAIL illegal_no_ready: got %0d readies, expected 0", readyCount1 - rc1);
        end
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 1);
        waitIdle();
        checks++;
        if (rd1 !== 8'hA5 || rd0 !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL illegal_ram_untouched: got %h/%h, expected a5", rd1, rd0);
        end
    endtask

    task automatic test_reset_midop();
        int rc1;
        applyStimulus(1'b0, 1'b1, 8'h05, 8'h11, 1);
        waitIdle();
        applyStimulus(1'b0, 1'b1, 8'h05, 8'h77, 1);
        rst = 1'b1;
        @(negedge clk);
        q1.delete();
        q0.delete();
        model[8'h05] = 8'h11;
        lastRead = 8'h00;
        modelIo = 8'h00;
        checks++;
        if (busy1 !== 1'b0 || busy0 !== 1'b0 || ready1 !== 1'b0 || ready0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midop_reset_state: got busy=%b/%b ready=%b/%b, expected 0", busy1, busy0, ready1, ready0);
        end
        checks++;
        if (rd1 !== 8'h00 || rd0 !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midop_reset_readdata: got %h/%h, expected 00", rd1, rd0);
        end
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h05, 8'h00, 1);
        waitIdle();
        checks++;
        if (rd1 !== 8'h11 || rd0 !== 8'h11) begin
            errors++;
            $display("[TB] FAIL midop_write_discarded: got %h/%h, expected 11", rd1, rd0);
        end
        applyStimulus(1'b0, 1'b1, 8'h06, 8'h42, 1);
        waitIdle();
        rc1 = readyCount1;
        @(negedge clk);
        rst = 1'b1;
        MemWrite = 1'b1;
        Addr = 8'h06;
        WriteData = 8'h99;
        @(negedge clk);
        rst = 1'b0;
        MemWrite = 1'b0;
        lastRead = 8'h00;
        modelIo = 8'h00;
        repeat (4) @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || readyCount1 !== rc1) begin
            errors++;
            $display("[TB] FAIL reset_beats_strobe: got busy=%b readies=%0d, expected 0/0", busy1, readyCount1 - rc1);
        end
        applyStimulus(1'b1, 1'b0, 8'h06, 8'h00, 1);
        waitIdle();
        checks++;
        if (rd1 !== 8'h42) begin
            errors++;
            $display("[TB] FAIL reset_strobe_ram: got %h, expected 42", rd1);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        applyStimulus(1'b0, 1'b1, 8'h30, 8'hC3, 1);
        while (ready1 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_ready_timeout: got ready=%b, expected 1", ready1);
        end
        applyStimulus(1'b1, 1'b0, 8'h30, 8'h00, 1);
        waitIdle();
        checks++;
        if (rd1 !== 8'hC3) begin
            errors++;
            $display("[TB] FAIL b2b_read: got %h, expected c3", rd1);
        end
    endtask

    task automatic test_mmio();
        logic [7:0] expIo;
`ifdef MEM_MMIO_EN
        expIo = 8'h5A;
`else
        expIo = 8'h00;
`endif
        applyStimulus(1'b0, 1'b1, 8'hFF, 8'h5A, 1);
        waitIdle();
        checks++;
        if (io1 !== expIo || io0 !== expIo) begin
            errors++;
            $display("[TB] FAIL mmio_ioout: got %h/%h, expected %h", io1, io0, expIo);
        end
        applyStimulus(1'b1, 1'b0, 8'hFF, 8'h00, 1);
        waitIdle();
        checks++;
        if (rd1 !== 8'h5A || rd0 !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL mmio_read_ff: got %h/%h, expected 5a", rd1, rd0);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_wait();
        test_illegal();
        test_reset_midop();
        test_back_to_back();
        test_mmio();
        repeat (3) @(negedge clk);
        checks++;
        if (q1.size() != 0 || q0.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_responses: got %0d/%0d outstanding, expected 0", q1.size(), q0.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish within 200000 time units");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU control FSM's MemRead/MemWrite strobes. It latches a single read or write request, inserts a configurable number of wait states, and performs the access on an internal synchronous RAM. It then reports completion with a one-cycle Ready pulse, and holds Busy high for the whole transaction so the datapath can stall. It sits between the control FSM/datapath and the data/instruction memory array.

## Interface
- DATA_W, 8, data word width
- ADDR_W, 8, address width; RAM depth is 2^ADDR_W words
- WAIT_CYCLES, 1, wait states inserted before the access (0..15)
- clk  input  1  system clock, all logic on posedge
- rst  input  1  reset; synchronous and active-high
- MemRead  input  1  read request strobe, sampled only in IDLE
- MemWrite  input  1  write request strobe, sampled only in IDLE
- Addr  input  ADDR_W  request address, sampled with the strobe
- WriteData  input  DATA_W  write data, sampled with the strobe
- ReadData  output  DATA_W  read result, registered, held until the next read completes
- Ready  output  1  one-cycle completion pulse (read or write)
- Busy  output  1  high whenever the state is not IDLE
- Err  output  1  one-cycle pulse on an illegal request (both strobes high)
- IOOut  output  DATA_W  memory-mapped output register (only meaningful with MEM_MMIO_EN)

## Operation
- States: IDLE, WAIT, ACCESS, DONE, ERROR.
- In IDLE, with exactly one strobe high at a posedge:
  - Latch the operation type, Addr and WriteData.
  - Load the wait counter with WAIT_CYCLES.
  - Go to WAIT, or go directly to ACCESS if WAIT_CYCLES == 0.
- In IDLE with both strobes high: go to ERROR, latch nothing, touch no memory.
- WAIT: decrement the counter each cycle; when the counter reaches 1, go to ACCESS. WAIT lasts exactly WAIT_CYCLES cycles.
- ACCESS: at the closing edge:
  - a write stores the latched data into RAM[latched addr];
  - a read loads ReadData from RAM[latched addr].
  - Then go to DONE.
- DONE: Ready = 1 for one cycle, then IDLE.
- ERROR: Err = 1 for one cycle, then IDLE.
- Strobes are ignored outside IDLE. There is no queueing; a strobe arriving while Busy is high is dropped.
- Address arithmetic is unsigned. The full 2^ADDR_W range is valid, with no wrap logic needed.
- RAM contents are not cleared by rst.

## Timing
- Reset values: state IDLE, ReadData 0, Ready 0, Busy 0, Err 0, IOOut 0, wait counter 0.
- Let E0 be the sampling edge. The state sequence after E0 is:
  - WAIT for WAIT_CYCLES cycles;
  - ACCESS in the cycle after edge E0+WAIT_CYCLES;
  - DONE in the cycle after edge E0+WAIT_CYCLES+1.
- Request-to-Ready latency is WAIT_CYCLES+2 cycles. Total occupancy, including the return to IDLE, is WAIT_CYCLES+2 cycles of Busy.
- Busy rises in the cycle after E0 and falls in the cycle after DONE.
- Back-to-back requests: a strobe is accepted at the edge that ends DONE+1, i.e. the first IDLE cycle. The strobe is not accepted during DONE.
- ReadData changes only at the closing edge of a read's ACCESS cycle. It is valid when Ready rises and stays stable through later write transactions.
- Reset mid-operation: return to IDLE at the next edge.
  - A write not yet past its ACCESS edge is discarded and RAM is unchanged.
  - Ready, Err and Busy drop.
  - ReadData is cleared to 0.
- rst asserted in the same cycle as a strobe: rst wins and the request is not accepted.
- The ERROR path takes 1 cycle: Err is high in the cycle after E0, with Busy = 1 in that same cycle.

## Configuration
- MEM_MMIO_EN, when defined: address all-ones (2^ADDR_W − 1) is mapped to IOOut.
  - A write there updates IOOut at the ACCESS edge and leaves RAM unchanged.
  - A read there returns IOOut.
  - Latency is unchanged.
- MEM_MMIO_EN, when not defined: address all-ones is ordinary RAM. IOOut is tied to 0 and no MMIO decode logic is present.

## Test plan
- Reset: assert rst for 2 cycles → ReadData=0, Ready=0, Busy=0, Err=0, IOOut=0.
- Write then read, WAIT_CYCLES=1:
  - MemWrite with Addr=0x10, WriteData=0xA5 → Ready pulses 3 cycles after E0, Busy high for 3 cycles.
  - Then MemRead with Addr=0x10 → ReadData=0xA5 with Ready.
- WAIT_CYCLES=0, read of unwritten-then-written address 0x20=0x3C → Ready 2 cycles after E0. A MemRead strobe during Busy is dropped and produces no second Ready.
- Both strobes high together in IDLE → Err=1 for one cycle, no Ready, RAM at Addr unchanged (verified by a later read).
- rst asserted in the WAIT cycle of a write of 0x77 to 0x05 → no Ready; a subsequent read of 0x05 returns the old value.
- MMIO with MEM_MMIO_EN: write 0x5A to 0xFF → IOOut=0x5A, RAM[0xFF] unchanged. Read of 0xFF → 0x5A. Without the macro, the same write lands in RAM and IOOut stays 0.
